// File: rtl/adder_bist_ctrl.sv
// Built-in self-test controller for a ripple adder: sweeps every {a,b,carry_in},
// checks {carry_out,sum} against a golden add, counts mismatches and logs the first one.
module adder_bist_ctrl #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [WIDTH-1:0]       a,
  output logic [WIDTH-1:0]       b,
  output logic                   carry_in,
  input  logic [WIDTH-1:0]       sum,
  input  logic                   carry_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   fail_valid,
  output logic [2*WIDTH:0]       fail_vec
);

  localparam int unsigned IDX_W = 2 * WIDTH + 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [SET_W-1:0]   settle_cnt;
  logic               settle_last;
  logic               idx_last;
  logic [WIDTH:0]     golden;
  logic               mismatch;

  assign idx_inc     = idx + IDX_W'(1);
  assign idx_last    = &idx;
  assign settle_last = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  // Golden result kept at WIDTH+1 bits so the MSB carry is checked against carry_out.
  assign golden      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign mismatch    = ({carry_out, sum} != golden);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (settle_last) state_next = CHECK;
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = idx_last ? DONE : DRIVE;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_next = DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx                  <= '0;
      settle_cnt           <= '0;
      {a, b, carry_in}     <= '0;
      err_count            <= '0;
      fail_valid           <= 1'b0;
      fail_vec             <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx              <= '0;
            settle_cnt       <= '0;
            {a, b, carry_in} <= '0;
            err_count        <= '0;
            fail_valid       <= 1'b0;
            fail_vec         <= '0;
          end
        end
        DRIVE: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + SET_W'(1);
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
            if (!fail_valid) begin
              fail_vec   <= idx;
              fail_valid <= 1'b1;
            end
          end
          // Operands load together with the index so they are stable for the whole DRIVE window.
          if (!idx_last) begin
            idx              <= idx_inc;
            {a, b, carry_in} <= idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Directed bench for adder_bist_ctrl: a behavioural adder with selectable faults is wired back,
// and a second controller with a narrow error counter watches a permanently faulty adder.
module tb_adder_bist_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;

  logic [3:0]  a, b, sum;
  logic        carry_in, carry_out;
  logic        busy, done, pass, fail_valid;
  logic [15:0] err_count;
  logic [8:0]  fail_vec;

  logic [3:0]  a2, b2, sum2;
  logic        carry_in2, carry_out2;
  logic        busy2, done2, pass2, fail_valid2;
  logic [3:0]  err_count2;
  logic [8:0]  fail_vec2;

  int unsigned fault_mode;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [4:0]  good, good2;

  always #5 clk = ~clk;

  // fault_mode: 0 healthy, 1 sum[0] stuck-at-0, 2 carry_out stuck-at-0
  always_comb begin
    good      = {1'b0, a} + {1'b0, b} + {4'b0, carry_in};
    sum       = good[3:0];
    carry_out = good[4];
    if (fault_mode == 1) sum[0] = 1'b0;
    if (fault_mode == 2) carry_out = 1'b0;
    good2      = {1'b0, a2} + {1'b0, b2} + {4'b0, carry_in2};
    sum2       = {good2[3:1], 1'b0};
    carry_out2 = good2[4];
  end

  adder_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a(a), .b(b), .carry_in(carry_in), .sum(sum), .carry_out(carry_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  adder_bist_ctrl #(.WIDTH(4), .SETTLE_CYCLES(1), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start),
    .a(a2), .b(b2), .carry_in(carry_in2), .sum(sum2), .carry_out(carry_out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_valid(fail_valid2), .fail_vec(fail_vec2)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fvalid"}, fail_valid, 0);
    check({tag, "_fvec"}, fail_vec, 0);
    check({tag, "_abc"}, {a, b, carry_in}, 0);
  endtask

  // Pulses start, optionally re-pulses it while busy, and checks done lands exactly 1024 edges later.
  task automatic sweep(input int unsigned repulse_at);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err_count, 0);
    check("start_abc", {a, b, carry_in}, 0);
    @(posedge clk); #1;
    check("check_state_abc", {a, b, carry_in}, 0);
    @(posedge clk); #1;
    check("vec1_abc", {a, b, carry_in}, 9'h001);
    for (int unsigned i = 3; i < 1024; i++) begin
      if (i == repulse_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    check("done_not_early", done, 0);
    check("busy_before_end", busy, 1);
    @(posedge clk); #1;
    check("done_at_1024", done, 1);
    check("busy_at_end", busy, 0);
    check("final_abc", {a, b, carry_in}, 9'h1FF);
  endtask

  initial begin
    fault_mode = 0;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_cleared("reset");

    // healthy adder
    sweep(0);
    check("ok_err", err_count, 0);
    check("ok_pass", pass, 1);
    check("ok_fvalid", fail_valid, 0);
    check("ok_fvec", fail_vec, 0);
    check("sat_err", err_count2, 4'hF);
    check("sat_pass", pass2, 0);
    check("sat_fvec", fail_vec2, 9'h001);

    // sum[0] stuck-at-0: every odd total fails, first at a=0,b=0,cin=1
    fault_mode = 1;
    sweep(0);
    check("s0_err", err_count, 256);
    check("s0_fvalid", fail_valid, 1);
    check("s0_fvec", fail_vec, 9'h001);
    check("s0_pass", pass, 0);

    // carry_out stuck-at-0: totals >= 16 fail, first at a=0,b=15,cin=1
    fault_mode = 2;
    sweep(0);
    check("co_err", err_count, 256);
    check("co_fvalid", fail_valid, 1);
    check("co_fvec", fail_vec, 9'h01F);
    check("co_pass", pass, 0);

    // reset mid-sweep, then a clean run
    fault_mode = 1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #1 check("mid_err_nonzero", (err_count != 0), 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check_cleared("midreset");
    repeat (3) @(posedge clk);
    #1 check("idle_stays", busy, 0);
    fault_mode = 0;
    sweep(0);
    check("rerun_err", err_count, 0);
    check("rerun_pass", pass, 1);

    // start while busy is ignored; start from DONE restarts
    sweep(101);
    check("repulse_pass", pass, 1);
    sweep(500);
    check("restart_pass", pass, 1);
    check("restart_fvalid", fail_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
